bmp_slave_feeder: RTL

- Transmit-side driver for one slave port of the image processing accelerator; it streams a BMP image into `slvN_*`.
- Pulls words from an upstream word source (memory reader or FIFO) over a valid/ready interface.
- Presents mode and processing value for the whole job, and counts words to a programmed length.
- Raises a done pulse after the last word is accepted via `slv_data_valid`/`slv_rdy`.
- Two instances sit in front of the accelerator, one per slave port.

---
 rtl/bmp_slave_feeder_pkg.sv | 23 ++
 rtl/bmp_skid_buffer.sv | 61 ++++++
 rtl/bmp_slave_feeder.sv | 113 +++++++++++
 3 files changed

// File: rtl/bmp_slave_feeder_pkg.sv
// Shared definitions for the BMP slave feeder: colour width, FSM state
// encoding and the processing-mode codes understood by the accelerator.
`ifndef COLOR_SIZE
`define COLOR_SIZE 8
`endif

package bmp_slave_feeder_pkg;

  localparam int COLOR_SIZE = `COLOR_SIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

  // Mode codes must stay in step with the processor's decoder.
  localparam logic [1:0] MODE_PASS      = 2'd0;
  localparam logic [1:0] MODE_BRIGHTEN  = 2'd1;
  localparam logic [1:0] MODE_DARKEN    = 2'd2;
  localparam logic [1:0] MODE_THRESHOLD = 2'd3;

endpackage

// File: rtl/bmp_skid_buffer.sv
// Two-entry valid/ready skid buffer. The output word sits in a register and
// in_ready depends only on occupancy, never on out_ready.
module bmp_skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [1:0]            count_q;
  logic                  push;
  logic                  pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // head_q only changes on a pop or when loading an empty buffer, so a
  // presented word stays put until it is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 skid_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= skid_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= skid_q;
            skid_q <= in_data;
          end
        end
        default: begin
          count_q <= count_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/bmp_slave_feeder.sv
// Streams one BMP job from an upstream word source into an accelerator slave
// port, holding mode/processing value for the job and pulsing done at the end.
module bmp_slave_feeder
  import bmp_slave_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             cfg_mode,
  input  logic [COLOR_SIZE-1:0]  cfg_proc_val,
  input  logic [COUNT_WIDTH-1:0] cfg_num_words,
  input  logic [DATA_WIDTH-1:0]  src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic [1:0]             slv_mode,
  output logic [COLOR_SIZE-1:0]  slv_proc_val,
  output logic [DATA_WIDTH-1:0]  slv_data,
  output logic                   slv_data_valid,
  input  logic                   slv_rdy,
  output logic                   busy,
  output logic                   done
);

  feeder_state_t          state_q;
  feeder_state_t          next_state;
  logic [COUNT_WIDTH-1:0] num_words_q;
  logic [COUNT_WIDTH-1:0] fetch_cnt_q;
  logic [COUNT_WIDTH-1:0] beat_cnt_q;
  logic                   start_accept;
  logic                   streaming;
  logic                   buf_in_ready;
  logic                   buf_out_valid;
  logic                   src_xfer;
  logic                   beat;
  logic                   last_beat;

  assign streaming      = (state_q == STREAM);
  assign src_ready      = streaming && buf_in_ready && (fetch_cnt_q < num_words_q);
  assign src_xfer       = src_valid && src_ready;
  assign slv_data_valid = streaming && buf_out_valid;
  assign beat           = slv_data_valid && slv_rdy;
  assign last_beat      = (beat_cnt_q == (num_words_q - COUNT_WIDTH'(1)));

  bmp_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (src_data),
    .in_valid  (src_xfer),
    .in_ready  (buf_in_ready),
    .out_data  (slv_data),
    .out_valid (buf_out_valid),
    .out_ready (slv_rdy && streaming)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state   = state_q;
    start_accept = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          next_state   = (cfg_num_words == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (beat && last_beat) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Config is captured only on an accepted start, so it stays valid for the
  // whole job and until the next job begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slv_mode     <= 2'd0;
      slv_proc_val <= '0;
      num_words_q  <= '0;
      fetch_cnt_q  <= '0;
      beat_cnt_q   <= '0;
    end else if (start_accept) begin
      slv_mode     <= cfg_mode;
      slv_proc_val <= cfg_proc_val;
      num_words_q  <= cfg_num_words;
      fetch_cnt_q  <= '0;
      beat_cnt_q   <= '0;
    end else begin
      if (src_xfer) fetch_cnt_q <= fetch_cnt_q + COUNT_WIDTH'(1);
      if (beat)     beat_cnt_q  <= beat_cnt_q + COUNT_WIDTH'(1);
    end
  end

endmodule
